// File: rtl/round_judge_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the round judge: FSM state encoding and LFSR constants.
package round_judge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARM    = 3'd1,
      ST_LIGHT  = 3'd2,
      ST_REPORT = 3'd3,
      ST_HOLD   = 3'd4
   } judge_state_e;

   // Seed loaded on reset, and feedback taps for x^8+x^6+x^5+x^4+1.
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   // One Fibonacci step: shift left, feed the XOR of the tapped bits into bit 0.
   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/round_judge_btn_sync.sv
`timescale 1ns/1ps
// Two-flop synchroniser for one raw pushbutton, plus a registered rising-edge pulse.
module round_judge_btn_sync (
   input  logic clk,
   input  logic rst,
   input  logic pb,
   output logic s2,
   output logic rise
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic prev_q, prev_d;
   logic rise_q, rise_d;

   // Next values of the synchroniser chain and the edge detector.
   always_comb begin
      s1_d   = pb;
      s2_d   = s1_q;
      prev_d = s2_q;
      rise_d = s2_q & ~prev_q;
   end

   // Synchroniser and edge flops, cleared by the active-low synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
      end
   end

   assign s2   = s2_q;
   assign rise = rise_q;

endmodule

// File: rtl/round_judge.sv
`timescale 1ns/1ps
// Round referee: random start-light delay, first-push detection, one winrnd pulse per round.
module round_judge
   import round_judge_pkg::*;
#(
   parameter logic [15:0] DELAY_MIN  = 16'd5000,
   parameter logic [7:0]  DELAY_MASK = 8'hFF,
   parameter logic [15:0] TIMEOUT    = 16'd40000,
   parameter logic [15:0] HOLD_CYC   = 16'd2000
) (
   input  logic clk,
   input  logic rst,
   input  logic pb_l,
   input  logic pb_r,
   input  logic game_over,
   output logic leds_on,
   output logic right,
   output logic winrnd
);

   logic s2_l, s2_r;
   logic rise_l, rise_r;
   logic tie, single;

   judge_state_e state_q, state_d;
   logic [15:0]  cnt_q, cnt_d;
   logic [7:0]   lfsr_q, lfsr_d;
   logic         leds_on_q, leds_on_d;
   logic         right_q, right_d;
   logic         winrnd_q, winrnd_d;

   round_judge_btn_sync u_sync_l (
      .clk  (clk),
      .rst  (rst),
      .pb   (pb_l),
      .s2   (s2_l),
      .rise (rise_l)
   );

   round_judge_btn_sync u_sync_r (
      .clk  (clk),
      .rst  (rst),
      .pb   (pb_r),
      .s2   (s2_r),
      .rise (rise_r)
   );

   assign tie    = rise_l & rise_r;
   assign single = rise_l ^ rise_r;

   // Next state, counter, LFSR and registered outputs; game_over overrides any push.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lfsr_d    = lfsr_step(lfsr_q);
      leds_on_d = leds_on_q;
      right_d   = right_q;
      winrnd_d  = 1'b0;

      if (game_over) begin
         state_d   = ST_IDLE;
         leds_on_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               leds_on_d = 1'b0;
               // Wait for both buttons released so a held button cannot start a round.
               if (!s2_l && !s2_r) begin
                  state_d = ST_ARM;
                  cnt_d   = DELAY_MIN + {8'h00, lfsr_q & DELAY_MASK};
               end
            end
            ST_ARM: begin
               leds_on_d = 1'b0;
               cnt_d     = cnt_q - 16'd1;
               if (tie) begin
                  state_d = ST_IDLE;
               end else if (single) begin
                  state_d  = ST_REPORT;
                  winrnd_d = 1'b1;
                  right_d  = rise_r;
               end else if (cnt_q <= 16'd1) begin
                  state_d   = ST_LIGHT;
                  leds_on_d = 1'b1;
                  cnt_d     = TIMEOUT;
               end
            end
            ST_LIGHT: begin
               leds_on_d = 1'b1;
               cnt_d     = cnt_q - 16'd1;
               if (tie) begin
                  state_d   = ST_IDLE;
                  leds_on_d = 1'b0;
               end else if (single) begin
                  state_d  = ST_REPORT;
                  winrnd_d = 1'b1;
                  right_d  = rise_r;
               end else if (cnt_q <= 16'd1) begin
                  state_d   = ST_IDLE;
                  leds_on_d = 1'b0;
               end
            end
            ST_REPORT: begin
               leds_on_d = 1'b0;
               cnt_d     = HOLD_CYC;
               state_d   = ST_HOLD;
            end
            ST_HOLD: begin
               cnt_d = cnt_q - 16'd1;
               if (cnt_q <= 16'd1) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               leds_on_d = 1'b0;
            end
         endcase
      end
   end

   // State, counter, LFSR and output registers with active-low synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         lfsr_q    <= LFSR_SEED;
         leds_on_q <= 1'b0;
         right_q   <= 1'b0;
         winrnd_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lfsr_q    <= lfsr_d;
         leds_on_q <= leds_on_d;
         right_q   <= right_d;
         winrnd_q  <= winrnd_d;
      end
   end

   assign leds_on = leds_on_q;
   assign right   = right_q;
   assign winrnd  = winrnd_q;

endmodule

// File: tb/tb_round_judge.sv
`timescale 1ns/1ps
// Directed bench for round_judge with a scoreboard of expected winrnd qualifiers.
module tb_round_judge;

   logic clk       = 1'b0;
   logic rst       = 1'b0;
   logic pb_l      = 1'b0;
   logic pb_r      = 1'b0;
   logic game_over = 1'b0;
   logic leds_on, right, winrnd;

   int n_pass  = 0;
   int n_total = 0;

   // Expected {right, leds_on} for each round that should produce winrnd.
   logic [1:0] sb[$];
   logic [7:0] m_lfsr;
   logic       win_prev = 1'b0;

   round_judge #(
      .DELAY_MIN  (16'd8),
      .DELAY_MASK (8'h0F),
      .TIMEOUT    (16'd32),
      .HOLD_CYC   (16'd4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pb_l      (pb_l),
      .pb_r      (pb_r),
      .game_over (game_over),
      .leds_on   (leds_on),
      .right     (right),
      .winrnd    (winrnd)
   );

   always #5 clk = ~clk;

   // Reference LFSR, x^8+x^6+x^5+x^4+1, seeded on reset.
   always @(posedge clk) begin
      if (!rst) m_lfsr <= 8'hA5;
      else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_leds(input logic lvl, input int max, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (leds_on !== lvl && n <= max);
   endtask

   task automatic wait_win(input int max, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (winrnd !== 1'b1 && n <= max);
   endtask

   // Scoreboard: every winrnd pulse must be expected, single-cycle, and carry the right qualifiers.
   always @(negedge clk) begin
      logic [1:0] e;
      if (rst === 1'b1 && winrnd === 1'b1) begin
         chk("win_one_cycle", {31'd0, win_prev}, 32'd0);
         chk("win_expected", {31'd0, sb.size() > 0}, 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("win_qualifiers", {30'd0, right, leds_on}, {30'd0, e});
         end
      end
      win_prev <= winrnd;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic [7:0] m;
      logic bad;

      // Reset for two cycles with buttons low.
      tick();
      tick();
      chk("rst_leds_on", {31'd0, leds_on}, 32'd0);
      chk("rst_right", {31'd0, right}, 32'd0);
      chk("rst_winrnd", {31'd0, winrnd}, 32'd0);
      rst = 1'b1;

      // First edge enters ARM with seed A5 -> delay 8 + 5 = 13.
      tick();
      bad = (leds_on !== 1'b0);
      for (int i = 1; i < 13; i++) begin
         tick();
         if (leds_on !== 1'b0) bad = 1'b1;
      end
      chk("arm_dark", {31'd0, bad}, 32'd0);
      tick();
      chk("light_after_13", {31'd0, leds_on}, 32'd1);

      // Right push in LIGHT, 4 cycles after the light.
      repeat (3) tick();
      pb_r = 1'b1;
      sb.push_back(2'b11);
      wait_win(8, n);
      chk("r1_latency", n, 32'd4);
      tick();
      chk("r1_win_drop", {31'd0, winrnd}, 32'd0);
      chk("r1_leds_off", {31'd0, leds_on}, 32'd0);
      chk("r1_right_hold", {31'd0, right}, 32'd1);
      pb_r = 1'b0;

      // HOLD of 4, IDLE, ARM entry 5 edges on; left pushed 3 cycles into ARM.
      repeat (5) tick();
      repeat (3) tick();
      pb_l = 1'b1;
      sb.push_back(2'b00);
      wait_win(8, n);
      chk("r2_latency", n, 32'd4);
      bad = 1'b0;
      repeat (20) begin
         tick();
         if (leds_on !== 1'b0 || winrnd !== 1'b0) bad = 1'b1;
      end
      chk("r2_dark_while_held", {31'd0, bad}, 32'd0);
      pb_l = 1'b0;

      // Tie in LIGHT.
      wait_leds(1'b1, 300, n);
      chk("r3_light_seen", {31'd0, n <= 300}, 32'd1);
      pb_l = 1'b1;
      pb_r = 1'b1;
      repeat (3) tick();
      chk("tie_pre_leds", {31'd0, leds_on}, 32'd1);
      tick();
      chk("tie_leds_off", {31'd0, leds_on}, 32'd0);
      chk("tie_no_win", {31'd0, winrnd}, 32'd0);
      bad = 1'b0;
      repeat (20) begin
         tick();
         if (leds_on !== 1'b0 || winrnd !== 1'b0) bad = 1'b1;
      end
      chk("tie_idle_while_held", {31'd0, bad}, 32'd0);
      pb_l = 1'b0;
      pb_r = 1'b0;

      // No push: light times out after 32 cycles, next delay follows the LFSR.
      wait_leds(1'b1, 300, n);
      chk("r4_light_seen", {31'd0, n <= 300}, 32'd1);
      wait_leds(1'b0, 100, n);
      chk("timeout_len", n, 32'd32);
      m = m_lfsr;
      wait_leds(1'b1, 300, n);
      chk("rearm_delay", n, 32'd9 + {28'd0, m[3:0]});

      // game_over mid-LIGHT with a push while frozen.
      repeat (2) tick();
      game_over = 1'b1;
      pb_r = 1'b1;
      tick();
      chk("go_leds_off", {31'd0, leds_on}, 32'd0);
      bad = 1'b0;
      repeat (15) begin
         tick();
         if (leds_on !== 1'b0 || winrnd !== 1'b0) bad = 1'b1;
      end
      chk("go_frozen", {31'd0, bad}, 32'd0);
      game_over = 1'b0;
      pb_r = 1'b0;

      // Reset on the edge that would report a round.
      wait_leds(1'b1, 300, n);
      chk("r6_light_seen", {31'd0, n <= 300}, 32'd1);
      pb_l = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      pb_l = 1'b0;
      tick();
      chk("rst_report_win", {31'd0, winrnd}, 32'd0);
      chk("rst_report_leds", {31'd0, leds_on}, 32'd0);
      chk("rst_report_right", {31'd0, right}, 32'd0);
      rst = 1'b1;
      wait_leds(1'b1, 100, n);
      chk("post_rst_delay", n, 32'd14);

      chk("sb_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
